// File: rtl/adder_share_arbiter_if.sv
// Requester and response bundle for adder_share_arbiter.
// Defining ADDER_ARB_CHAIN_EN adds the per-requester req_chain lane.
interface adder_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sub;
  logic [NUM_REQ-1:0]    req_cin;
`ifdef ADDER_ARB_CHAIN_EN
  logic [NUM_REQ-1:0]    req_chain;
`endif
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;

`ifdef ADDER_ARB_CHAIN_EN
  modport master (
    output req_valid, req_a, req_b, req_sub, req_cin, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_cin, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
`endif
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external 32-bit adder with a one-entry response register.
// Optional carry chaining for multi-word adds is enabled by ADDER_ARB_CHAIN_EN.
module adder_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_share_arbiter_if.slave bus,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_out,
  input  logic                 add_cout
);
  localparam int DATA_W = 32;

  function automatic logic f_ovf(input logic signed [DATA_W-1:0] a,
                                 input logic signed [DATA_W-1:0] b,
                                 input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic [ID_W-1:0]   r_ptr;
  logic              r_vld_p1;
  logic [ID_W-1:0]   r_id_p1;
  logic [DATA_W-1:0] r_sum_p1;
  logic              r_cout_p1;
  logic              r_ovf_p1;
`ifdef ADDER_ARB_CHAIN_EN
  logic [NUM_REQ-1:0] r_carry;
`endif

  logic               w_can_acc;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_upper;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_hit;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic               w_sub;
  logic               w_cin;
  logic               w_chain;

  // Stage p0: grant and operand mux (combinational, same cycle as the adder)
  always_comb begin
    w_can_acc = !r_vld_p1 || bus.rsp_ready;
    w_req     = (w_can_acc && !rst) ? bus.req_valid : '0;
    w_upper   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_upper[j] = (j >= int'(r_ptr));
    end
    w_hi    = w_req & w_upper;
    // Requests at or above the pointer take priority; otherwise wrap to index 0.
    w_cand  = (|w_hi) ? w_hi : w_req;
    w_gnt   = '0;
    w_hit   = 1'b0;
    w_win   = '0;
    w_a     = '0;
    w_b     = '0;
    w_sub   = 1'b0;
    w_cin   = 1'b0;
    w_chain = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_hit && w_cand[j]) begin
        w_hit    = 1'b1;
        w_gnt[j] = 1'b1;
        w_win    = ID_W'(j);
        w_a      = bus.req_a[j*DATA_W +: DATA_W];
        w_b      = bus.req_b[j*DATA_W +: DATA_W];
        w_sub    = bus.req_sub[j];
        w_cin    = bus.req_sub[j] ? 1'b1 : bus.req_cin[j];
`ifdef ADDER_ARB_CHAIN_EN
        w_chain  = bus.req_chain[j];
        if (bus.req_chain[j]) begin
          w_cin = r_carry[j];
        end
`endif
      end
    end
  end

  assign add_a   = w_a;
  assign add_b   = w_sub ? ~w_b : w_b;
  assign add_cin = w_cin;

  always_comb begin
    if (w_chain) begin
      w_ptr_nxt = w_win;
    end else if (w_win == ID_W'(NUM_REQ-1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + ID_W'(1);
    end
  end

  // Stage p1: response register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_vld_p1  <= 1'b0;
      r_id_p1   <= '0;
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_ovf_p1  <= 1'b0;
    end else if (w_hit) begin
      r_ptr     <= w_ptr_nxt;
      r_vld_p1  <= 1'b1;
      r_id_p1   <= w_win;
      r_sum_p1  <= add_out;
      r_cout_p1 <= add_cout;
      r_ovf_p1  <= f_ovf(add_a, add_b, add_out);
    end else if (bus.rsp_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

`ifdef ADDER_ARB_CHAIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_gnt[j]) begin
          r_carry[j] <= add_cout;
        end
      end
    end
  end
`endif

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_vld_p1;
  assign bus.rsp_id    = r_id_p1;
  assign bus.rsp_sum   = r_sum_p1;
  assign bus.rsp_cout  = r_cout_p1;
  assign bus.rsp_ovf   = r_ovf_p1;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: vector table, hand sequences, random vs. model.
// Chain sequence is compiled in when ADDER_ARB_CHAIN_EN is defined.
module tb_adder_share_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  logic [31:0] add_a, add_b, add_out;
  logic        add_cin, add_cout;

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_out  (add_out),
    .add_cout (add_cout)
  );

  // Stand-in for the shared combinational adder
  assign {add_cout, add_out} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  logic [NUM_REQ-1:0] v_valid, v_sub, v_cin, v_chain;
  logic [31:0]        op_a [NUM_REQ];
  logic [31:0]        op_b [NUM_REQ];
  logic               v_rsp_ready;

  always_comb begin
    bus.req_valid = v_valid;
    bus.req_sub   = v_sub;
    bus.req_cin   = v_cin;
    bus.rsp_ready = v_rsp_ready;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*32 +: 32] = op_a[i];
      bus.req_b[i*32 +: 32] = op_b[i];
    end
`ifdef ADDER_ARB_CHAIN_EN
    bus.req_chain = v_chain;
`endif
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string name, input logic vld, input logic [ID_W-1:0] id,
                         input logic [31:0] sum, input logic cout, input logic ovf);
    chk({name, "_valid"}, 64'(bus.rsp_valid), 64'(vld));
    chk({name, "_id"},    64'(bus.rsp_id),    64'(id));
    chk({name, "_sum"},   64'(bus.rsp_sum),   64'(sum));
    chk({name, "_cout"},  64'(bus.rsp_cout),  64'(cout));
    chk({name, "_ovf"},   64'(bus.rsp_ovf),   64'(ovf));
  endtask

  // Reference: true arithmetic of A+B+cin or A-B, carry as "no borrow" for subtract
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input logic cin);
    longint ua, ub, us, sa, sb, ss;
    logic   cout, ovf;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      us   = ua - ub;
      ss   = sa - sb;
      cout = (ua >= ub);
    end else begin
      us   = ua + ub + longint'(cin);
      ss   = sa + sb + longint'(cin);
      cout = (us >= 64'sd4294967296);
    end
    ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {ovf, cout, us[31:0]};
  endfunction

  function automatic int ref_winner(input logic [NUM_REQ-1:0] v, input int ptr);
    int j;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (ptr + k) % NUM_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_REQ-1:0] gnt_last, exp_rdy;
    logic [33:0]        r;
    int                 win, m_ptr;
    logic               m_vld, m_cout, m_ovf;
    logic [ID_W-1:0]    m_id;
    logic [31:0]        m_sum;

    tbl[0] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[1] = '{1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[5] = '{1, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
    tbl[7] = '{1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1;
    v_valid = '1; v_sub = '0; v_cin = '0; v_chain = '0; v_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 32'd0;
      op_b[i] = 32'd0;
    end
    #4;
    chk_rsp("reset", 1'b0, '0, 32'd0, 1'b0, 1'b0);
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    step(); step();
    chk("reset_ready_hold", 64'(bus.req_ready), 64'd0);

    // Reset arriving while a response is pending
    rst = 1'b0; v_valid = 2'b01; v_rsp_ready = 1'b0;
    op_a[0] = 32'd3; op_b[0] = 32'd4; op_a[1] = 32'd1; op_b[1] = 32'd1;
    #3 chk("mid_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk_rsp("mid_pending", 1'b1, 1'd0, 32'd7, 1'b0, 1'b0);
    v_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.rsp_sum), 64'd0);
    step();
    rst = 1'b0; v_valid = 2'b11; v_rsp_ready = 1'b1;
    #3 chk("post_rst_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk("post_rst_id", 64'(bus.rsp_id), 64'd0);

    for (int t = 0; t < 8; t++) begin
      v_valid          = NUM_REQ'(1) << tbl[t].id;
      op_a[tbl[t].id]  = tbl[t].a;
      op_b[tbl[t].id]  = tbl[t].b;
      v_sub[tbl[t].id] = tbl[t].sub;
      v_cin[tbl[t].id] = tbl[t].cin;
      #3 chk($sformatf("vec%0d_ready", t), 64'(bus.req_ready), 64'(v_valid));
      step();
      chk_rsp($sformatf("vec%0d", t), 1'b1, ID_W'(tbl[t].id), tbl[t].sum, tbl[t].cout, tbl[t].ovf);
    end

    // Drain with no new request: valid drops, data holds
    v_valid = '0; v_sub = '0; v_cin = '0;
    step();
    chk_rsp("drain", 1'b0, ID_W'(tbl[7].id), tbl[7].sum, tbl[7].cout, tbl[7].ovf);

    op_a[0] = 32'd10; op_b[0] = 32'd1; op_a[1] = 32'd20; op_b[1] = 32'd2;
    v_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #3 chk($sformatf("rr%0d_ready", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      step();
      chk($sformatf("rr%0d_id", c), 64'(bus.rsp_id), 64'(c % 2));
      chk($sformatf("rr%0d_sum", c), 64'(bus.rsp_sum), (c % 2 == 0) ? 64'd11 : 64'd22);
    end

    v_valid = 2'b01; op_a[0] = 32'd100; op_b[0] = 32'd200; v_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3 chk($sformatf("bp%0d_ready", c), 64'(bus.req_ready), 64'd0);
      step();
      chk_rsp($sformatf("bp%0d", c), 1'b1, 1'd1, 32'd22, 1'b0, 1'b0);
    end
    v_rsp_ready = 1'b1;
    #3 chk("bp_release_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk_rsp("bp_release", 1'b1, 1'd0, 32'd300, 1'b0, 1'b0);
    v_valid = '0;

    // Random traffic against the model, starting from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_vld = 1'b0; m_id = '0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_ptr = 0;
    gnt_last = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v_valid[i] || gnt_last[i]) begin
          v_valid[i] = ($urandom_range(0, 2) != 0);
          op_a[i]    = rnd_word();
          op_b[i]    = rnd_word();
          v_sub[i]   = $urandom_range(0, 1) == 1;
          v_cin[i]   = $urandom_range(0, 1) == 1;
        end
      end
      v_rsp_ready = ($urandom_range(0, 3) != 0);
      win = (!m_vld || v_rsp_ready) ? ref_winner(v_valid, m_ptr) : -1;
      exp_rdy = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
      #3 chk("rnd_ready", 64'(bus.req_ready), 64'(exp_rdy));
      step();
      if (win >= 0) begin
        r      = ref_op(op_a[win], op_b[win], v_sub[win], v_cin[win]);
        m_sum  = r[31:0];
        m_cout = r[32];
        m_ovf  = r[33];
        m_id   = ID_W'(win);
        m_vld  = 1'b1;
        m_ptr  = (win + 1) % NUM_REQ;
      end else if (v_rsp_ready) begin
        m_vld = 1'b0;
      end
      chk_rsp("rnd", m_vld, m_id, m_sum, m_cout, m_ovf);
      gnt_last = exp_rdy;
    end
    v_valid = '0; v_rsp_ready = 1'b1;

`ifdef ADDER_ARB_CHAIN_EN
    rst = 1'b1;
    step();
    rst = 1'b0; v_sub = '0; v_cin = '0;
    v_valid = 2'b01; v_chain = 2'b00; op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'd1;
    #3 chk("ch_lo_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk_rsp("ch_lo", 1'b1, 1'd0, 32'd0, 1'b1, 1'b0);
    v_chain = 2'b01; op_a[0] = 32'd0; op_b[0] = 32'd0;
    #3 chk("ch_hi_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk_rsp("ch_hi", 1'b1, 1'd0, 32'd1, 1'b0, 1'b0);
    // Pointer stays on req0: req1 is held off; chained sub uses stored carry 0
    v_valid = 2'b11; v_sub[0] = 1'b1; op_a[0] = 32'd5; op_b[0] = 32'd3;
    op_a[1] = 32'd4; op_b[1] = 32'd6; v_chain[1] = 1'b0;
    #3 chk("ch_hold_ready", 64'(bus.req_ready), 64'h1);
    step();
    chk_rsp("ch_hold", 1'b1, 1'd0, 32'd1, 1'b1, 1'b0);
    v_valid = 2'b10; v_chain = '0; v_sub = '0;
    #3 chk("ch_drop_ready", 64'(bus.req_ready), 64'h2);
    step();
    chk_rsp("ch_drop", 1'b1, 1'd1, 32'd10, 1'b0, 1'b0);
    v_valid = '0;
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational 32-bit adder unit between NUM_REQ requesters, e.g. the ALU add/sub path and the branch-target/PC path.
- Arbitrates round-robin, muxes the winner's operands onto the adder, and captures sum/carry/overflow in a one-entry response register.
- The response register has a valid/ready handshake and carries the requester ID.
- Sits between the issue logic and the single adder instance in the KGP_RISC datapath.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, 1, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant; request accepted this cycle.
- req_a  input  NUM_REQ*32  operand A, requester i at bits [32*i+31:32*i].
- req_b  input  NUM_REQ*32  operand B, same packing.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B+cin.
- req_cin  input  NUM_REQ  carry-in for add (ignored when sub=1).
- add_a  output  32  to adder input a.
- add_b  output  32  to adder input b.
- add_cin  output  1  to adder cin.
- add_out  input  32  from adder out (combinational, same cycle).
- add_cout  input  1  from adder cout.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  requester index of the result.
- rsp_sum  output  32  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_ovf  output  1  registered signed overflow.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rsp_id=0.
  - Round-robin pointer=0; stored carries=0.
  - req_ready=0 while rst is high.
  - Any pending response is discarded.
- Accept condition: can_acc = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only when can_acc.
  - Winner is the first i with req_valid[i]=1, scanning from pointer upward with wrap NUM_REQ-1 -> 0.
  - req_ready is one-hot at the winner; all zero if no winner.
- Operand mux:
  - Winner present: add_a = A; add_b = sub ? ~B : B; add_cin = sub ? 1 : cin.
  - No winner: add_a=0, add_b=0, add_cin=0.
- Capture, on a clk edge with a winner:
  - rsp_sum <= add_out; rsp_cout <= add_cout; rsp_id <= winner; rsp_valid <= 1.
  - rsp_ovf <= (add_a[31]==add_b[31]) && (add_out[31]!=add_a[31]).
  - pointer <= (winner+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the accept edge to rsp_valid.
- Throughput: 1 op/cycle while rsp_ready=1.
- Drain without new grant: rsp_valid && rsp_ready and no winner -> rsp_valid <= 0; data fields hold their last value.
- Backpressure: rsp_valid && !rsp_ready -> no grant; all rsp_* stable; pointer unchanged.
- Simultaneous drain and accept in one cycle: the new result overwrites; rsp_valid stays 1.
- Pointer advances only on grant; idle cycles do not move it.
- Subtract borrow: rsp_cout=1 means no borrow (A>=B unsigned).
- Requesters must hold their operands stable while req_valid=1 and req_ready=0.

Optional Feature:
- Macro: ADDER_ARB_CHAIN_EN.
- When defined:
  - Adds input req_chain [NUM_REQ-1:0].
  - Per-requester stored carry register, updated with add_cout on each grant to that requester.
  - If the winner has req_chain=1: add_cin = stored carry. For sub, stored carry is used in place of 1; B is still inverted.
  - After a grant with req_chain=1, the pointer stays on that requester, so multi-word adds complete back-to-back.
  - Stored carry clears on reset.
- When undefined: no req_chain port, no stored carries; behaviour exactly as above.

Test Plan:
- Reset mid-response: rsp_valid=1, assert rst -> rsp_valid=0 immediately, rsp_sum=0; first grant after release goes to req 0.
- Single add: req0 A=0x7FFFFFFF, B=1, sub=0, cin=0 -> next cycle rsp_sum=0x80000000, cout=0, ovf=1, id=0.
- Subtract: req1 A=5, B=7, sub=1 -> rsp_sum=0xFFFFFFFE, cout=0, ovf=0, id=1.
- Round-robin: both valid for 4 cycles, rsp_ready=1 -> grant sequence 0,1,0,1; rsp_id follows one cycle later.
- Backpressure: rsp_ready=0 for 3 cycles with req0 valid -> req_ready=0 and rsp_* frozen; on rsp_ready=1, req0 is granted the same cycle and rsp_valid stays 1.
- (ADDER_ARB_CHAIN_EN) 64-bit add via req0: low word 0xFFFFFFFF+1 (chain=0), then high word 0+0 (chain=1) -> low word sum 0, cout=1; high word sum 1; req1 held off until chain drops.
